// File: rtl/lm70_spi_responder.sv
// lm70_spi_responder
// Sensor end of the LM70 SCK/CS/SIO link. Serialises {temp_i, 5'b11111}
// MSB-first on SIO while CS is low, then samples a 16-bit command word
// written by the master. SCK, CS and SIO are oversampled on clk, which must
// run at least 8x the SCK frequency.
//
// Optional feature macro: LM70_RESP_SHUTDOWN_EN
//   defined   : command 16'h00FF enters shutdown, 16'h0000 leaves it; in
//               shutdown the frame word is DEV_ID.
//   undefined : no command decode, shutdown_o stays 0.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cs_n_i       chip select from master (async, active-low)
//   sck_i        SPI clock from master (async, CPOL=0)
//   sio_i        SIO pad input (master write data)
//   sio_o        SIO pad output data
//   sio_oe       SIO pad output enable, 1 = drive
//   temp_i       11-bit two's-complement temperature, LSB = 0.25 C
//   shutdown_o   shutdown mode flag
//   frame_done_o one-clk pulse when a frame of >= 16 bits ends
//
// state | meaning
// IDLE  | waiting for an armed CS fall
// READ  | shifting the 16-bit frame word out on SIO
// WRITE | sampling the 16-bit command from SIO
// HOLD  | 32 bits seen, further SCK edges ignored until CS rises

module lm70_spi_responder #(
    parameter logic [15:0] DEV_ID = 16'h8100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n_i,
    input  logic        sck_i,
    input  logic        sio_i,
    output logic        sio_o,
    output logic        sio_oe,
    input  logic [10:0] temp_i,
    output logic        shutdown_o,
    output logic        frame_done_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

    state_t      state_q, state_d;
    logic        cs_s1, cs_s2, cs_s3;
    logic        sck_s1, sck_s2, sck_s3;
    logic        sio_s1, sio_s2;
    logic        sync_valid;
    logic        armed_q, armed_d;
    logic [15:0] word_q, word_d;
    logic [15:0] cmd_q, cmd_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    logic        sd_q, sd_d;
    logic        sck_rise, sck_fall, cs_rise, cs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1      <= 1'b1;
            cs_s2      <= 1'b1;
            cs_s3      <= 1'b1;
            sck_s1     <= 1'b0;
            sck_s2     <= 1'b0;
            sck_s3     <= 1'b0;
            sio_s1     <= 1'b0;
            sio_s2     <= 1'b0;
            sync_valid <= 1'b0;
        end else begin
            cs_s1      <= cs_n_i;
            cs_s2      <= cs_s1;
            cs_s3      <= cs_s2;
            sck_s1     <= sck_i;
            sck_s2     <= sck_s1;
            sck_s3     <= sck_s2;
            sio_s1     <= sio_i;
            sio_s2     <= sio_s1;
            sync_valid <= 1'b1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            word_q    <= '0;
            cmd_q     <= '0;
            bit_cnt_q <= '0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            sd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            word_q    <= word_d;
            cmd_q     <= cmd_d;
            bit_cnt_q <= bit_cnt_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            sd_q      <= sd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cmd_d     = cmd_q;
        bit_cnt_d = bit_cnt_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        sd_d      = sd_q;
        // The synchronisers reset to "CS high", so arming waits until
        // sync_valid shows that cs_s1/cs_s2 hold real pin samples. A CS held
        // low through reset therefore never opens a partial frame.
        armed_d   = armed_q | (sync_valid & cs_s1 & cs_s2);

        if (state_q == IDLE) begin
            if (cs_fall && armed_q) begin
                state_d   = READ;
                word_d    = sd_q ? DEV_ID : {temp_i, 5'b11111};
                bit_cnt_d = '0;
                oe_d      = 1'b1;
            end
        end else if (cs_rise) begin
            // CS wins over any SCK edge detected in the same clk.
            state_d = IDLE;
            oe_d    = 1'b0;
            done_d  = (bit_cnt_q >= 6'd16);
`ifdef LM70_RESP_SHUTDOWN_EN
            if (state_q == HOLD) begin
                if (cmd_q == 16'h00FF)      sd_d = 1'b1;
                else if (cmd_q == 16'h0000) sd_d = 1'b0;
            end
`endif
        end else begin
            unique case (state_q)
                READ: begin
                    if (sck_fall) word_d = {word_q[14:0], 1'b0};
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd15) begin
                            state_d = WRITE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (sck_rise) begin
                        cmd_d     = {cmd_q[14:0], sio_s2};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd31) state_d = HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef LM70_RESP_SHUTDOWN_EN
    // Command is captured but has no consumer in this build.
    logic cmd_unused;
    assign cmd_unused = ^cmd_q;
`endif

    assign sio_o        = word_q[15];
    assign sio_oe       = oe_q;
    assign shutdown_o   = sd_q;
    assign frame_done_o = done_q;

endmodule

// File: doc/lm70_spi_responder.md
# lm70_spi_responder

SPI responder that emulates the LM70 temperature sensor on the SCK/CS/SIO link, i.e. the sensor end of the link our temperature-display master drives. It serialises a supplied 11-bit temperature word MSB-first onto SIO while CS is low, then samples a 16-bit command from the master to enter or leave shutdown. It is used for on-chip loopback demos and as the sensor model in system benches. The block runs on its own faster clock and oversamples SCK and CS.

## Interface
- `DEV_ID`, default 16'h8100: word shifted out instead of temperature while in shutdown.
- `clk` in 1: system clock; must be ≥ 8× the SCK frequency.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cs_n_i` in 1: chip select from master, active-low, asynchronous to clk.
- `sck_i` in 1: SPI clock from master, CPOL=0, asynchronous to clk.
- `sio_i` in 1: SIO pad input; master write data.
- `sio_o` out 1: SIO pad output data.
- `sio_oe` out 1: SIO pad output enable, 1 = drive.
- `temp_i` in 11: two's-complement temperature, LSB = 0.25 °C.
- `shutdown_o` out 1: shutdown mode flag.
- `frame_done_o` out 1: one-clk pulse at the end of a frame of at least 16 bits.

## Operation
- Synchronisers: 2-flop on `cs_n_i`, `sck_i`, and `sio_i`. Reset levels are cs=1 and sck=0. A third register on sck and cs provides edge detection.
- Arming: after reset, `armed`=0. It is set when synchronised cs is seen high. A CS falling edge is ignored unless `armed`=1, so reset mid-frame never starts a partial frame.
- States: IDLE, READ, WRITE, HOLD. A 6-bit `bit_cnt` counts synchronised SCK rising edges within the frame.
- IDLE → READ on a synchronised CS fall (armed):
  - Latch the frame word: `{temp_i, 5'b11111}`, or `DEV_ID` if `shutdown_o`=1.
  - Clear `bit_cnt`.
  - Set `sio_oe`=1 and present the MSB on `sio_o`.
- READ:
  - On each SCK falling edge, shift the word left and present the next bit.
  - On each rising edge, increment `bit_cnt`.
  - At `bit_cnt`=16, go to WRITE and set `sio_oe`=0.
- WRITE:
  - On each rising edge, shift the synchronised `sio_i` into a 16-bit `cmd_sr`, MSB first, and increment `bit_cnt`.
  - At `bit_cnt`=32, go to HOLD.
- HOLD: all further SCK edges are ignored.
- Synchronised CS rise from any non-IDLE state → IDLE, with `sio_oe`=0:
  - `frame_done_o` pulses if `bit_cnt`≥16.
  - Command decode applies only from HOLD; see Configuration.
  - A frame aborted in READ or WRITE has no command effect.
- Simultaneous events: a CS rise in the same clk as an SCK edge means CS wins and the edge is ignored. Rising and falling SCK edges cannot be detected in the same clk.
- `temp_i` is sampled only at the frame start. Changes mid-frame do not affect the frame in progress.

## Timing
- Reset values: `sio_o`=0, `sio_oe`=0, `shutdown_o`=0, `frame_done_o`=0, state IDLE, `bit_cnt`=0, `armed`=0.
- Pin edge to detected edge: 3 clk (2 sync + 1 edge register).
- `sio_o` and `sio_oe` update 1 clk after detection, i.e. ≤4 clk after the pin edge.
- With clk ≥ 8×SCK, data is stable ≥ half an SCK period minus 4 clk before the master's sampling rising edge.
- `sio_oe` drops ≤4 clk after the 16th rising edge. This gives hold after the master samples bit 0.
- `frame_done_o` and the `shutdown_o` update occur 4 clk after the CS rise pin edge.
- Master reads of only 8 bits are legal: CS rises in READ, giving no `frame_done_o` and no command.

## Configuration
- `LM70_RESP_SHUTDOWN_EN` defined:
  - At CS rise from HOLD, `cmd_sr`=16'h00FF sets `shutdown_o`=1.
  - `cmd_sr`=16'h0000 clears `shutdown_o`.
  - Any other value leaves `shutdown_o` unchanged.
  - In shutdown, frames shift out `DEV_ID`.
- Undefined:
  - No command decode; `cmd_sr` is still shifted but has no effect.
  - `shutdown_o` is tied to 0 and `DEV_ID` is never sent.
  - WRITE/HOLD sequencing and `frame_done_o` are unchanged.

## Test plan
- `temp_i`=11'h0C8 (50 °C), 16-clock read at clk/16 SCK → SIO bits 0001_1001_0001_1111, `sio_oe` low after 16th rise, `frame_done_o` one pulse.
- `temp_i`=11'h7FC (−1 °C), 8-clock read then CS high → master sees 8'hFF, no `frame_done_o`, `sio_oe`=0.
- 32-clock frame writing 16'h00FF (macro on) → `shutdown_o`=1; next read returns 16'h8100; writing 16'h0000 clears it; writing 16'h1234 leaves it unchanged.
- Same 00FF frame with macro off → `shutdown_o` stays 0; next read returns temperature.
- Assert `rst_n` low mid-READ with `cs_n_i` held low, release → no drive until CS goes high then low again; outputs at reset values.
- CS rise coincident with SCK rise at bit 31 → frame aborted from WRITE, no command effect, `frame_done_o` pulses.
